// File: rtl/coffee_vend_ctrl.sv
// Coffee vending controller: coin credit accumulation, brew req/ack sequencing
// with timeout, and change/refund paid out as alternate-cycle 5-cent pulses.
module coffee_vend_ctrl #(
    parameter int PRICE_UNITS = 3,
    parameter int CREDIT_W    = 5,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          coins,
    input  logic                cancel,
    input  logic                brew_ack,
    output logic                coin_accept,
    output logic                coin_reject,
    output logic                brew_req,
    output logic                change_pulse,
    output logic                vend_done,
    output logic                fault,
    output logic [CREDIT_W-1:0] credit,
    output logic [1:0]          dbg_state
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_BREW    = 2'd2;
    localparam logic [1:0] ST_CHANGE  = 2'd3;

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [TMR_W-1:0]    TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [CREDIT_W-1:0] PRICE    = CREDIT_W'(PRICE_UNITS);

    logic [1:0]          state, state_n;
    logic [TMR_W-1:0]    timer, timer_n;
    logic [CREDIT_W-1:0] credit_n, coin_add, sum, after_vend;
    logic                coin_valid;
    logic                brew_req_n, change_n, vend_n, fault_n, reject_n;

    assign dbg_state = state;

    always_comb begin
        coin_valid = (coins == 2'b10) || (coins == 2'b01);
        coin_add   = (coins == 2'b10) ? CREDIT_W'(1) :
                     (coins == 2'b01) ? CREDIT_W'(2) : '0;
        sum        = credit + coin_add;
        after_vend = credit - PRICE;

        state_n    = state;
        credit_n   = credit;
        timer_n    = timer;
        brew_req_n = brew_req;
        change_n   = 1'b0;
        vend_n     = 1'b0;
        fault_n    = 1'b0;
        reject_n   = (coins == 2'b11);

        case (state)
            ST_IDLE, ST_COLLECT: begin
                // Price check on the updated credit: a paying coin beats cancel.
                if (sum >= PRICE) begin
                    state_n    = ST_BREW;
                    credit_n   = sum;
                    brew_req_n = 1'b1;
                    timer_n    = '0;
                end else if (sum != '0) begin
                    credit_n = sum;
                    state_n  = cancel ? ST_CHANGE : ST_COLLECT;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            // brew_req is held high until brew_ack is sampled high; the
            // request completes on that edge and ack is ignored otherwise.
            ST_BREW: begin
                reject_n = reject_n | coin_valid;
                if (brew_ack) begin
                    brew_req_n = 1'b0;
                    vend_n     = 1'b1;
                    credit_n   = after_vend;
                    state_n    = (after_vend != '0) ? ST_CHANGE : ST_IDLE;
                end else if (timer == TMR_LAST) begin
                    brew_req_n = 1'b0;
                    fault_n    = 1'b1;
                    state_n    = ST_CHANGE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: begin
                // Pulse one cycle, rest one cycle; leave after the last rest.
                reject_n = reject_n | coin_valid;
                if (change_pulse) begin
                    if (credit == '0) state_n = ST_IDLE;
                end else if (credit != '0) begin
                    change_n = 1'b1;
                    credit_n = credit - 1'b1;
                end else begin
                    state_n = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            credit       <= '0;
            timer        <= '0;
            coin_accept  <= 1'b1;
            coin_reject  <= 1'b0;
            brew_req     <= 1'b0;
            change_pulse <= 1'b0;
            vend_done    <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_n;
            credit       <= credit_n;
            timer        <= timer_n;
            coin_accept  <= (state_n == ST_IDLE) || (state_n == ST_COLLECT);
            coin_reject  <= reject_n;
            brew_req     <= brew_req_n;
            change_pulse <= change_n;
            vend_done    <= vend_n;
            fault        <= fault_n;
        end
    end

endmodule

// File: tb/tb_coffee_vend_ctrl.sv
// Directed bench for coffee_vend_ctrl (PRICE 3, timeout 8); change pulses
// are scoreboarded against an expected-credit queue.
module tb_coffee_vend_ctrl;

    localparam int W = 5;
    localparam logic [1:0] S_IDLE = 2'd0, S_COLLECT = 2'd1, S_BREW = 2'd2, S_CHANGE = 2'd3;

    logic         clk = 1'b0;
    logic         reset, cancel, brew_ack;
    logic [1:0]   coins;
    logic         coin_accept, coin_reject, brew_req, change_pulse, vend_done, fault;
    logic [W-1:0] credit;
    logic [1:0]   dbg_state;

    logic [W-1:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    coffee_vend_ctrl #(.PRICE_UNITS(3), .CREDIT_W(W), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .reset(reset), .coins(coins), .cancel(cancel), .brew_ack(brew_ack),
        .coin_accept(coin_accept), .coin_reject(coin_reject), .brew_req(brew_req),
        .change_pulse(change_pulse), .vend_done(vend_done), .fault(fault),
        .credit(credit), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [1:0] st, input logic [W-1:0] cr);
        chk({tag, "_state"}, 32'(dbg_state), 32'(st));
        chk({tag, "_credit"}, 32'(credit), 32'(cr));
    endtask

    // Scoreboard: every change pulse must match the next queued credit value.
    always @(negedge clk) begin
        if (!reset && change_pulse) begin
            if (exp_q.size() == 0) chk("unexpected_pulse", 32'd1, 32'd0);
            else chk("pulse_credit", 32'(credit), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        reset = 1'b1; coins = 2'b00; cancel = 1'b0; brew_ack = 1'b0;
        step(); step();
        chk_st("rst", S_IDLE, 0);
        chk("rst_accept", 32'(coin_accept), 32'd1);
        chk("rst_outs", 32'({coin_reject, brew_req, change_pulse, vend_done, fault}), 32'd0);
        reset = 1'b0;

        // 1: 5c then 10c reaches price, ack after 4 cycles
        coins = 2'b10; step(); chk_st("t1_c1", S_COLLECT, 1);
        coins = 2'b01; step(); chk_st("t1_c2", S_BREW, 3);
        chk("t1_req", 32'(brew_req), 32'd1);
        chk("t1_accept", 32'(coin_accept), 32'd0);
        coins = 2'b00;
        for (int i = 0; i < 3; i++) begin step(); chk("t1_req_hold", 32'(brew_req), 32'd1); end
        brew_ack = 1'b1; step();
        chk("t1_vend", 32'({vend_done, brew_req}), 32'b10);
        chk_st("t1_done", S_IDLE, 0);
        brew_ack = 1'b0; step();
        chk("t1_vend_pulse", 32'(vend_done), 32'd0);

        // ack outside BREW is ignored
        brew_ack = 1'b1; step();
        chk("ack_idle", 32'(vend_done), 32'd0);
        brew_ack = 1'b0;

        // 2: 10c + 10c overshoots, one 5c change
        coins = 2'b01; step(); chk_st("t2_c1", S_COLLECT, 2);
        coins = 2'b01; step(); chk_st("t2_c2", S_BREW, 4);
        coins = 2'b00; brew_ack = 1'b1; exp_q.push_back(0); step();
        chk_st("t2_ack", S_CHANGE, 1);
        brew_ack = 1'b0; step();
        chk("t2_pulse", 32'(change_pulse), 32'd1);
        step();
        chk_st("t2_end", S_IDLE, 0);
        chk("t2_pulse_low", 32'(change_pulse), 32'd0);

        // 3: two 5c then cancel -> two pulses one low cycle apart
        coins = 2'b10; step(); coins = 2'b10; step(); chk_st("t3_c2", S_COLLECT, 2);
        coins = 2'b00; cancel = 1'b1; exp_q.push_back(1); exp_q.push_back(0); step();
        chk_st("t3_cancel", S_CHANGE, 2);
        cancel = 1'b0;
        step(); chk("t3_p1", 32'(change_pulse), 32'd1);
        step(); chk("t3_gap", 32'(change_pulse), 32'd0);
        step(); chk("t3_p2", 32'(change_pulse), 32'd1);
        step(); chk_st("t3_end", S_IDLE, 0);
        chk("t3_no_req", 32'(brew_req), 32'd0);

        // coin and cancel together below price: coin credited and refunded
        coins = 2'b10; step();
        cancel = 1'b1; exp_q.push_back(1); exp_q.push_back(0); step();
        chk_st("cc_refund", S_CHANGE, 2);
        coins = 2'b00; cancel = 1'b0;
        for (int i = 0; i < 4; i++) step();
        chk_st("cc_end", S_IDLE, 0);

        // coin and cancel together reaching price: brew wins
        coins = 2'b01; step();
        coins = 2'b10; cancel = 1'b1; step();
        chk_st("cc_brew", S_BREW, 3);
        coins = 2'b00; cancel = 1'b0; brew_ack = 1'b1; step();
        chk_st("cc_brew_done", S_IDLE, 0);
        brew_ack = 1'b0;

        // 4: timeout, brew_req held 8 cycles, full refund
        coins = 2'b01; step(); coins = 2'b10; step(); coins = 2'b00;
        chk_st("t4_brew", S_BREW, 3);
        hi = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!brew_req) break;
            hi++;
        end
        chk("t4_req_cycles", 32'(hi), 32'd8);
        chk("t4_fault", 32'(fault), 32'd1);
        chk_st("t4_change", S_CHANGE, 3);
        exp_q.push_back(2); exp_q.push_back(1); exp_q.push_back(0);
        step(); chk("t4_fault_pulse", 32'(fault), 32'd0);
        for (int i = 0; i < 5; i++) step();
        chk_st("t4_end", S_IDLE, 0);

        // 5: invalid coin in IDLE, valid coin during BREW
        coins = 2'b11; step();
        chk("t5_rej_idle", 32'(coin_reject), 32'd1);
        chk_st("t5_idle", S_IDLE, 0);
        coins = 2'b00; step();
        chk("t5_rej_low", 32'(coin_reject), 32'd0);
        coins = 2'b01; step(); coins = 2'b01; step();
        coins = 2'b10; cancel = 1'b1; step();
        chk("t5_rej_brew", 32'(coin_reject), 32'd1);
        chk_st("t5_brew", S_BREW, 4);
        coins = 2'b00; cancel = 1'b0; brew_ack = 1'b1; exp_q.push_back(0); step();
        chk_st("t5_ack", S_CHANGE, 1);
        brew_ack = 1'b0; step(); step();
        chk_st("t5_end", S_IDLE, 0);

        // 6: reset during CHANGE with credit 2
        coins = 2'b10; step(); step(); coins = 2'b00; cancel = 1'b1; step(); cancel = 1'b0;
        chk_st("t6_change", S_CHANGE, 2);
        reset = 1'b1; step();
        chk_st("t6_rst", S_IDLE, 0);
        chk("t6_pulse", 32'(change_pulse), 32'd0);
        chk("t6_accept", 32'(coin_accept), 32'd1);
        reset = 1'b0; step(); step();
        chk_st("t6_after", S_IDLE, 0);

        chk("pulse_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
